// File: rtl/sprite_pool_pkg.sv
// Shared types, coordinate widths and the wrap helper for the sprite pool.
package sprite_pool_pkg;

  // Internal coordinate widths: x up to 639 and y up to 479, with headroom for signed sums.
  localparam int X_W   = 12;
  localparam int Y_W   = 11;
  localparam int SUM_W = 13;
  localparam int RGB_W = 12;

  // Stored velocity width. Spawned velocities are sign-extended into this field,
  // so VEL_W at the top level must not exceed it.
  localparam int VEL_STORE_W = 10;

  // Default screen geometry used by the VGA timing this unit feeds.
  localparam int DEF_SCREEN_W = 640;
  localparam int DEF_SCREEN_H = 480;

  // Complete state of one sprite slot.
  typedef struct packed {
    logic                          alive;
    logic [X_W-1:0]                x;
    logic [Y_W-1:0]                y;
    logic signed [VEL_STORE_W-1:0] vx;
    logic signed [VEL_STORE_W-1:0] vy;
    logic [RGB_W-1:0]              rgb;
  } obj_t;

  // Bring position + velocity back into [0, modulus). Because |v| < modulus,
  // at most one correction is ever needed.
  function automatic logic [X_W-1:0] wrap_coord(input logic signed [SUM_W-1:0] sum,
                                                input logic signed [SUM_W-1:0] modulus);
    logic signed [SUM_W-1:0] res;
    res = sum;
    if (sum < 0)
      res = sum + modulus;
    else if (sum >= modulus)
      res = sum - modulus;
    return res[X_W-1:0];
  endfunction

endpackage

// File: rtl/sprite_slot.sv
// One sprite slot: holds its object state, applies spawn load, frame advance
// and collision kill, and reports whether the current pixel falls inside it.
module sprite_slot
  import sprite_pool_pkg::*;
#(
  parameter int OBJ_W    = 32,
  parameter int OBJ_H    = 32,
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             load,
  input  obj_t             load_obj,
  input  logic             advance,
  input  logic             kill,
  input  logic [31:0]      pxl_x,
  input  logic [31:0]      pxl_y,
  output logic             alive,
  output logic             hit,
  output logic [RGB_W-1:0] rgb
);

  obj_t                    obj;
  logic signed [SUM_W-1:0] sum_x;
  logic signed [SUM_W-1:0] sum_y;
  logic [31:0]             dx;
  logic [31:0]             dy;

  // Next-frame position before wrapping, computed as signed sums.
  always_comb begin
    sum_x = $signed({1'b0, obj.x}) + SUM_W'($signed(obj.vx));
    sum_y = $signed({2'b00, obj.y}) + SUM_W'($signed(obj.vy));
  end

  // Slot state: a spawn load overrides the frame advance, so a sprite spawned
  // on the frame pulse starts exactly at its spawn coordinates.
  // NOTE: every field is reset here -- there are only N_OBJ small registers and
  // a dead slot must read as all-zero immediately after reset.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      // NOTE: sequential state uses non-blocking assignments so every slot and
      // the output registers all see the same pre-edge values.
      obj <= '0;
    end else if (load) begin
      obj <= load_obj;
    end else begin
      if (advance && obj.alive) begin
        obj.x <= wrap_coord(sum_x, SUM_W'(SCREEN_W));
        obj.y <= Y_W'(wrap_coord(sum_y, SUM_W'(SCREEN_H)));
      end
      if (kill)
        obj.alive <= 1'b0;
    end
  end

  // Hit test with 32-bit unsigned differences: a pixel left of or above the
  // sprite wraps to a huge value and misses, so nothing draws across edges.
  assign dx    = pxl_x - 32'(obj.x);
  assign dy    = pxl_y - 32'(obj.y);
  assign hit   = obj.alive && (dx < 32'(OBJ_W)) && (dy < 32'(OBJ_H));
  assign alive = obj.alive;
  assign rgb   = obj.rgb;

endmodule

// File: rtl/sprite_pool_unit.sv
// Pool of N_OBJ movable sprites: free-slot allocation for spawns, per-slot
// state, lowest-index-wins pixel priority and registered RGB/Draw outputs.
module sprite_pool_unit
  import sprite_pool_pkg::*;
#(
  parameter int N_OBJ    = 8,
  parameter int OBJ_W    = 32,
  parameter int OBJ_H    = 32,
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H,
  parameter int VEL_W    = 8,
  localparam int ID_W    = (N_OBJ > 1) ? $clog2(N_OBJ) : 1
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             startOfFrame,
  input  logic [31:0]      pxl_x,
  input  logic [31:0]      pxl_y,
  input  logic [N_OBJ-1:0] collision,
  input  logic             spawn_valid,
  output logic             spawn_ready,
  input  logic [10:0]      spawn_x,
  input  logic [9:0]       spawn_y,
  input  logic [VEL_W-1:0] spawn_vx,
  input  logic [VEL_W-1:0] spawn_vy,
  input  logic [11:0]      spawn_rgb,
  output logic [3:0]       Red,
  output logic [3:0]       Green,
  output logic [3:0]       Blue,
  output logic             Draw,
  output logic [ID_W-1:0]  hit_id,
  output logic [N_OBJ-1:0] alive_mask
);

  logic [N_OBJ-1:0] alive_vec;
  logic [N_OBJ-1:0] hit_vec;
  logic [N_OBJ-1:0] load_vec;
  logic [RGB_W-1:0] slot_rgb [N_OBJ];
  logic [ID_W-1:0]  free_idx;
  logic [ID_W-1:0]  win_idx;
  logic [RGB_W-1:0] win_rgb;
  logic             any_hit;
  logic             spawn_fire;
  obj_t             spawn_obj;

  assign alive_mask  = alive_vec;
  assign spawn_ready = ~&alive_vec;
  assign spawn_fire  = spawn_valid & spawn_ready;

  // Object image loaded into the chosen slot, with velocities sign-extended.
  always_comb begin
    // NOTE: every combinationally written signal gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    spawn_obj       = '0;
    spawn_obj.alive = 1'b1;
    spawn_obj.x     = {1'b0, spawn_x};
    spawn_obj.y     = {1'b0, spawn_y};
    spawn_obj.vx    = VEL_STORE_W'($signed(spawn_vx));
    spawn_obj.vy    = VEL_STORE_W'($signed(spawn_vy));
    spawn_obj.rgb   = spawn_rgb;
  end

  // Lowest-index dead slot; scanning downward lets the lowest index win.
  always_comb begin
    free_idx = '0;
    for (int i = N_OBJ - 1; i >= 0; i--) begin
      if (!alive_vec[i])
        free_idx = ID_W'(i);
    end
  end

  // One-hot load strobe for the slot receiving an accepted spawn.
  always_comb begin
    load_vec = '0;
    if (spawn_fire)
      load_vec[free_idx] = 1'b1;
  end

  // Pixel priority: lowest-index hitting slot supplies colour and id.
  always_comb begin
    win_idx = '0;
    win_rgb = '0;
    any_hit = |hit_vec;
    for (int i = N_OBJ - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        win_idx = ID_W'(i);
        win_rgb = slot_rgb[i];
      end
    end
  end

  // Sprite slots, all sharing the spawn image, frame pulse and pixel position.
  for (genvar g = 0; g < N_OBJ; g++) begin : g_slot
    sprite_slot #(
      .OBJ_W    (OBJ_W),
      .OBJ_H    (OBJ_H),
      .SCREEN_W (SCREEN_W),
      .SCREEN_H (SCREEN_H)
    ) u_slot (
      .clk      (clk),
      .resetN   (resetN),
      .load     (load_vec[g]),
      .load_obj (spawn_obj),
      .advance  (startOfFrame),
      .kill     (collision[g]),
      .pxl_x    (pxl_x),
      .pxl_y    (pxl_y),
      .alive    (alive_vec[g]),
      .hit      (hit_vec[g]),
      .rgb      (slot_rgb[g])
    );
  end

  // Registered pixel outputs; hit_id keeps the last winner when nothing draws.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      Draw   <= 1'b0;
      Red    <= 4'h0;
      Green  <= 4'h0;
      Blue   <= 4'h0;
      hit_id <= '0;
    end else begin
      Draw <= any_hit;
      if (any_hit) begin
        {Red, Green, Blue} <= win_rgb;
        hit_id             <= win_idx;
      end else begin
        {Red, Green, Blue} <= 12'h000;
      end
    end
  end

endmodule

// File: tb/tb_sprite_pool_unit.sv
// Directed bench for sprite_pool_unit: the driver queues expected pixel and
// slot-state responses, and a negedge monitor compares them one cycle later.
module tb_sprite_pool_unit;

  logic        clk = 1'b0;
  logic        resetN;
  logic        startOfFrame;
  logic [31:0] pxl_x;
  logic [31:0] pxl_y;
  logic [7:0]  collision;
  logic        spawn_valid;
  logic        spawn_ready;
  logic [10:0] spawn_x;
  logic [9:0]  spawn_y;
  logic [7:0]  spawn_vx;
  logic [7:0]  spawn_vy;
  logic [11:0] spawn_rgb;
  logic [3:0]  Red, Green, Blue;
  logic        Draw;
  logic [2:0]  hit_id;
  logic [7:0]  alive_mask;

  sprite_pool_unit dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .pxl_x        (pxl_x),
    .pxl_y        (pxl_y),
    .collision    (collision),
    .spawn_valid  (spawn_valid),
    .spawn_ready  (spawn_ready),
    .spawn_x      (spawn_x),
    .spawn_y      (spawn_y),
    .spawn_vx     (spawn_vx),
    .spawn_vy     (spawn_vy),
    .spawn_rgb    (spawn_rgb),
    .Red          (Red),
    .Green        (Green),
    .Blue         (Blue),
    .Draw         (Draw),
    .hit_id       (hit_id),
    .alive_mask   (alive_mask)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        kind;   // 0: pixel response, 1: slot state
    logic        draw;
    logic [11:0] rgb;
    logic [2:0]  id;
    logic [7:0]  mask;
    logic        ready;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    vectors     = 0;
  int    miscompares = 0;
  logic  probe_req;
  logic  probe_d;
  logic [2:0] last_id;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Marks the cycle whose registered output answers a queued request.
  always @(posedge clk or negedge resetN) begin
    if (!resetN) probe_d <= 1'b0;
    else         probe_d <= probe_req;
  end

  // Monitor: pops one expectation per answered request.
  always @(negedge clk) begin
    exp_t  e;
    string nm;
    if (probe_d) begin
      if (exp_q.size() == 0) begin
        check("unexpected_response", 32'd1, 32'd0);
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (!e.kind)
          check(nm, {16'd0, Draw, Red, Green, Blue, hit_id}, {16'd0, e.draw, e.rgb, e.id});
        else
          check(nm, {23'd0, alive_mask, spawn_ready}, {23'd0, e.mask, e.ready});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic spawn(input int x, input int y, input int vx, input int vy,
                       input logic [11:0] rgb, input logic sof = 1'b0);
    spawn_x      = 11'(x);
    spawn_y      = 10'(y);
    spawn_vx     = 8'(vx);
    spawn_vy     = 8'(vy);
    spawn_rgb    = rgb;
    spawn_valid  = 1'b1;
    startOfFrame = sof;
    tick();
    spawn_valid  = 1'b0;
    startOfFrame = 1'b0;
  endtask

  task automatic frame();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
  endtask

  task automatic collide(input logic [7:0] m);
    collision = m;
    tick();
    collision = 8'h00;
  endtask

  task automatic probe(input string name, input int x, input int y,
                       input logic draw, input logic [11:0] rgb, input logic [2:0] id);
    exp_t e;
    e = '{kind: 1'b0, draw: draw, rgb: rgb, id: (draw ? id : last_id), mask: 8'h00, ready: 1'b0};
    if (draw) last_id = id;
    exp_q.push_back(e);
    name_q.push_back(name);
    pxl_x     = 32'(x);
    pxl_y     = 32'(y);
    probe_req = 1'b1;
    tick();
    probe_req = 1'b0;
  endtask

  task automatic state(input string name, input logic [7:0] mask, input logic ready);
    exp_t e;
    e = '{kind: 1'b1, draw: 1'b0, rgb: 12'h000, id: 3'd0, mask: mask, ready: ready};
    exp_q.push_back(e);
    name_q.push_back(name);
    probe_req = 1'b1;
    tick();
    probe_req = 1'b0;
  endtask

  // Bounded wait for the monitor to consume everything queued.
  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++)
      @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      check("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      name_q.delete();
    end
  endtask

  initial begin
    resetN       = 1'b0;
    startOfFrame = 1'b0;
    pxl_x        = 32'd0;
    pxl_y        = 32'd0;
    collision    = 8'h00;
    spawn_valid  = 1'b0;
    spawn_x      = '0;
    spawn_y      = '0;
    spawn_vx     = '0;
    spawn_vy     = '0;
    spawn_rgb    = '0;
    probe_req    = 1'b0;
    last_id      = 3'd0;
    repeat (3) @(posedge clk);
    #1 resetN = 1'b1;

    // Reset state
    state("reset_state", 8'h00, 1'b1);
    probe("reset_pixel", 0, 0, 1'b0, 12'h000, 3'd0);

    // Basic spawn and one frame: slot0 -> (103,48)
    spawn(100, 50, 3, -2, 12'hF00);
    frame();
    probe("slot0_origin", 103, 48, 1'b1, 12'hF00, 3'd0);
    probe("slot0_right_edge_out", 135, 48, 1'b0, 12'h000, 3'd0);
    probe("slot0_far_corner_in", 134, 79, 1'b1, 12'hF00, 3'd0);
    probe("slot0_left_of_sprite", 102, 48, 1'b0, 12'h000, 3'd0);

    // Wrap: x 638+5 -> 3, y 1-4 -> 477; slot0 moves on to (106,46)
    spawn(638, 300, 5, 0, 12'h0A0);
    spawn(300, 1, 0, -4, 12'h00A);
    frame();
    probe("wrap_x_positive", 3, 300, 1'b1, 12'h0A0, 3'd1);
    probe("wrap_y_negative", 300, 477, 1'b1, 12'h00A, 3'd2);
    probe("no_hit_holds_id", 2, 300, 1'b0, 12'h000, 3'd0);
    state("three_alive", 8'h07, 1'b1);

    // Fill the pool; a ninth spawn is ignored
    spawn(500, 400, 0, 0, 12'h123);
    spawn(600, 440, 0, 0, 12'h444);
    spawn(600, 440, 0, 0, 12'h555);
    spawn(600, 440, 0, 0, 12'h666);
    spawn(600, 440, 0, 0, 12'h777);
    state("pool_full", 8'hFF, 1'b0);
    spawn(50, 50, 0, 0, 12'hABC);
    state("ninth_spawn_ignored", 8'hFF, 1'b0);
    probe("stacked_lowest_wins", 600, 440, 1'b1, 12'h444, 3'd4);
    probe("ignored_spawn_not_drawn", 50, 50, 1'b0, 12'h000, 3'd0);

    // Collision frees slot3; the next spawn lands there
    collide(8'h08);
    state("slot3_killed", 8'hF7, 1'b1);
    spawn(50, 50, 2, 1, 12'hABC);
    state("slot3_respawned", 8'hFF, 1'b0);
    probe("slot3_new_sprite", 50, 50, 1'b1, 12'hABC, 3'd3);

    // Overlap priority between slots 1 and 2; repeat collision on dead slots
    collide(8'h06);
    state("slots12_killed", 8'hF9, 1'b1);
    collide(8'h06);
    state("dead_collision_ignored", 8'hF9, 1'b1);
    spawn(200, 200, 0, 0, 12'h0F0);
    spawn(190, 190, 0, 0, 12'h00F);
    probe("overlap_lower_index", 200, 200, 1'b1, 12'h0F0, 3'd1);
    probe("overlap_slot2_only", 195, 195, 1'b1, 12'h00F, 3'd2);

    // Spawn coincident with frame: slot0 un-advanced, slot3 -> (52,51)
    collide(8'h01);
    state("slot0_killed", 8'hFE, 1'b1);
    spawn(20, 30, 1, 1, 12'hF0F, 1'b1);
    probe("sof_spawn_unadvanced", 20, 30, 1'b1, 12'hF0F, 3'd0);
    probe("sof_existing_advanced", 83, 82, 1'b1, 12'hABC, 3'd3);
    probe("sof_miss_holds_id", 19, 30, 1'b0, 12'h000, 3'd0);
    state("sof_all_alive", 8'hFF, 1'b0);

    // Asynchronous reset while drawing
    probe("draw_before_reset", 20, 30, 1'b1, 12'hF0F, 3'd0);
    drain();
    @(negedge clk);
    check("draw_high_pre_reset", {31'd0, Draw}, 32'd1);
    #2 resetN = 1'b0;
    #1;
    check("async_draw_clear", {31'd0, Draw}, 32'd0);
    check("async_rgb_clear", {20'd0, Red, Green, Blue}, 32'd0);
    check("async_mask_clear", {24'd0, alive_mask}, 32'd0);
    last_id = 3'd0;
    @(posedge clk);
    #1 resetN = 1'b1;
    state("post_reset_state", 8'h00, 1'b1);
    probe("post_reset_no_draw", 20, 30, 1'b0, 12'h000, 3'd0);

    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sprite_pool_unit.md
Name: sprite_pool_unit

Overview:
Parametrised successor to the single-sprite move/draw unit. Holds up to N_OBJ independent movable sprites, each with position, signed per-frame velocity, colour and alive flag. Positions advance once per frame with screen wrap-around. New sprites arrive over a valid/ready spawn handshake, and per-object collision pulses retire them. Per-pixel hit test feeds a priority mux that drives registered RGB/Draw into the existing VGA object mux.

Parameters:
N_OBJ, 8, number of sprite slots (1..16)
OBJ_W, 32, sprite width in pixels
OBJ_H, 32, sprite height in pixels
SCREEN_W, 640, horizontal wrap modulus
SCREEN_H, 480, vertical wrap modulus
VEL_W, 8, signed velocity width (pixels/frame)

Ports:
clk  in  1  system clock
resetN  in  1  asynchronous active-low reset
startOfFrame  in  1  one-cycle pulse per frame
pxl_x  in  32  current pixel x
pxl_y  in  32  current pixel y
collision  in  N_OBJ  per-slot collision pulse
spawn_valid  in  1  spawn request
spawn_ready  out  1  a free slot exists
spawn_x  in  11  initial x (0..SCREEN_W-1)
spawn_y  in  10  initial y (0..SCREEN_H-1)
spawn_vx  in  VEL_W  signed x velocity
spawn_vy  in  VEL_W  signed y velocity
spawn_rgb  in  12  {R,G,B} colour
Red/Green/Blue  out  4 each  pixel colour
Draw  out  1  pixel belongs to a sprite
hit_id  out  $clog2(N_OBJ)  slot drawn at this pixel
alive_mask  out  N_OBJ  live slots

Behaviour:
- Reset (async, resetN=0): all slots dead; positions, velocities and colours 0; Draw=0; RGB=0; hit_id=0; alive_mask=0; spawn_ready=1 once released.
- spawn_ready = ~&alive_mask (combinational from registered state).
- Spawn: on spawn_valid & spawn_ready, the lowest-index dead slot loads x, y, vx, vy, rgb and sets alive in the next cycle. Spawn_valid while not ready: ignored, no state change.
- Frame update: on startOfFrame, every alive slot updates x <= (x+vx) mod SCREEN_W and y <= (y+vy) mod SCREEN_H, all in parallel.
  - Wrap rule: if the sum is negative, add the modulus; if it is >= the modulus, subtract it. |v| < modulus, so one correction suffices.
  - Arithmetic is signed, 12-bit x and 11-bit y internally.
- Spawn coincident with startOfFrame: the new slot takes spawn values un-advanced. The other slots update normally.
- Collision: collision[i]=1 on an alive slot clears its alive bit next cycle. It is ignored on dead slots.
  - A collision and a spawn in the same cycle cannot target the same slot, because spawn selects only dead slots.
  - A slot freed by collision is spawnable from the following cycle.
- Hit test per alive slot: hit_i = (pxl_x-x) < OBJ_W and (pxl_y-y) < OBJ_H, using 32-bit unsigned differences. There is no wrap-around drawing across screen edges.
- Priority: the lowest index hit wins.
- Output latency: 1 cycle, fully registered.
  - Any hit: Draw=1, RGB = winning slot's colour, hit_id = winning index.
  - No hit: Draw=0, RGB=0, hit_id holds its previous value.
- Reset asserted mid-frame: outputs clear immediately (async). Nothing is drawn until new spawns arrive.

Decomposition:
- Package sprite_pool_pkg:
  - obj_t struct {alive, x[11:0], y[10:0], vx, vy, rgb[11:0]}
  - constants for screen dimensions and coordinate widths
  - wrap function
- One natural sub-module, sprite_slot, instantiated N_OBJ times via generate:
  - holds one obj_t
  - applies load/update/kill
  - outputs hit and rgb
- The top level implements free-slot priority encode, hit priority mux and output registers.

Test Plan:
- Reset, spawn (100,50,v=+3,-2,rgb=F00), one startOfFrame -> slot0 at (103,48); pixel (103,48) gives Draw=1 and R=F one cycle later; pixel (135,48) gives Draw=0.
- Spawn x=638, vx=+5, then one frame -> x=3; spawn y=1, vy=-4, then one frame -> y=477.
- Spawn N_OBJ=8 sprites -> spawn_ready=0 and a 9th spawn is ignored; collision[3] pulse -> alive_mask bit3=0, ready=1, next spawn lands in slot 3.
- Slots 1 and 2 overlap at (200,200) with colours 0F0 and 00F -> Draw=1, G=F, hit_id=1.
- spawn_valid coincident with startOfFrame -> new sprite at spawn coordinates, existing sprites advanced.
- resetN pulsed low mid-line while Draw=1 -> Draw, RGB and alive_mask drop to 0 without waiting for a clk edge.
